// File: rtl/hart_miss_ctrl_pkg.sv
// Shared definitions for the multi-hart miss controller: per-hart state
// encoding and refill type bits.
package hart_miss_ctrl_pkg;

  localparam int HART_ST_W = 2;

  typedef enum logic [HART_ST_W-1:0] {
    HART_ST_RUN    = 2'd0,
    HART_ST_PEND   = 2'd1,
    HART_ST_WAIT   = 2'd2,
    HART_ST_RESUME = 2'd3
  } hart_st_e;

  localparam logic MISS_DC = 1'b1;
  localparam logic MISS_IC = 1'b0;

endpackage

// File: rtl/hart_miss_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when enabled.
module hart_miss_ctrl_rr_arbiter
  import hart_miss_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg, ptr_next;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_reg) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (en) ptr_next = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/hart_miss_ctrl.sv
// Multi-hart cache-miss controller: parks missing harts, arbitrates refill
// requests round-robin, limits outstanding refills and emits resume pulses.
module hart_miss_ctrl
  import hart_miss_ctrl_pkg::*;
#(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = 2,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ic_miss,
  input  logic [HART_ID_W-1:0]             ic_hart_id,
  input  logic [ADDR_W-1:0]                ic_pc,
  input  logic                             dc_miss,
  input  logic [HART_ID_W-1:0]             dc_hart_id,
  input  logic [ADDR_W-1:0]                dc_addr,
  input  logic [ADDR_W-1:0]                dc_pc,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [HART_ID_W-1:0]             req_hart_id,
  output logic [ADDR_W-1:0]                req_addr,
  output logic                             req_is_dc,
  input  logic                             rsp_valid,
  input  logic [HART_ID_W-1:0]             rsp_hart_id,
  output logic [HART_NUM-1:0]              hart_run,
  output logic                             resume_valid,
  output logic [HART_ID_W-1:0]             resume_hart_id,
  output logic [ADDR_W-1:0]                resume_pc,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
  output logic                             err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [ADDR_W-1:0]    addr_nx [HART_NUM];
  logic [ADDR_W-1:0]    pc_cur  [HART_NUM];
  logic [HART_NUM-1:0]  is_dc_nx, pend_next, resume_vec, miss_bad, rsp_hit, grant;
  logic                 hs, rsp_ok, arb_en;
  logic                 req_valid_reg, req_valid_next;
  logic [HART_ID_W-1:0] req_hart_id_reg, req_hart_id_next;
  logic [ADDR_W-1:0]    req_addr_reg, req_addr_next;
  logic                 req_is_dc_reg, req_is_dc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 err_reg, err_next;
  logic [HART_ID_W-1:0] grant_id;
  logic [ADDR_W-1:0]    grant_addr;
  logic                 grant_dc;

  assign hs = req_valid_reg & req_ready;

  generate
    for (genvar gi = 0; gi < HART_NUM; gi++) begin : g_hart
      localparam logic [HART_ID_W-1:0] ID = HART_ID_W'(gi);
      hart_st_e          st_reg, st_next;
      logic [ADDR_W-1:0] addr_reg, addr_next, pc_reg, pc_next;
      logic              is_dc_reg, is_dc_next;
      logic              dc_hit, ic_hit;

      // A same-hart I-miss loses to the D-miss and is dropped without error.
      assign dc_hit = dc_miss && (dc_hart_id == ID);
      assign ic_hit = ic_miss && (ic_hart_id == ID) && !dc_hit;

      always_comb begin
        st_next    = st_reg;
        addr_next  = addr_reg;
        pc_next    = pc_reg;
        is_dc_next = is_dc_reg;
        case (st_reg)
          HART_ST_RUN: begin
            if (dc_hit) begin
              st_next    = HART_ST_PEND;
              addr_next  = dc_addr;
              pc_next    = dc_pc;
              is_dc_next = MISS_DC;
            end else if (ic_hit) begin
              st_next    = HART_ST_PEND;
              addr_next  = ic_pc;
              pc_next    = ic_pc;
              is_dc_next = MISS_IC;
            end
          end
          HART_ST_PEND: if (hs && (req_hart_id_reg == ID)) st_next = HART_ST_WAIT;
          HART_ST_WAIT: if (rsp_valid && (rsp_hart_id == ID)) st_next = HART_ST_RESUME;
          default:      st_next = HART_ST_RUN;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          st_reg    <= HART_ST_RUN;
          addr_reg  <= '0;
          pc_reg    <= '0;
          is_dc_reg <= 1'b0;
        end else begin
          st_reg    <= st_next;
          addr_reg  <= addr_next;
          pc_reg    <= pc_next;
          is_dc_reg <= is_dc_next;
        end
      end

      assign hart_run[gi]   = (st_reg == HART_ST_RUN);
      assign resume_vec[gi] = (st_reg == HART_ST_RESUME);
      assign pend_next[gi]  = (st_next == HART_ST_PEND);
      assign miss_bad[gi]   = (dc_hit || ic_hit) && (st_reg != HART_ST_RUN);
      assign rsp_hit[gi]    = rsp_valid && (rsp_hart_id == ID) && (st_reg == HART_ST_WAIT);
      assign addr_nx[gi]    = addr_next;
      assign is_dc_nx[gi]   = is_dc_next;
      assign pc_cur[gi]     = pc_reg;
    end
  endgenerate

  assign rsp_ok   = |rsp_hit;
  assign cnt_next = cnt_reg + CNT_W'(hs) - CNT_W'(rsp_ok);
  assign err_next = err_reg | (|miss_bad) | (rsp_valid & ~rsp_ok);
  // Arbitrate on next-cycle pending state so a miss can be requested one cycle later.
  assign arb_en   = (!req_valid_reg || hs) && (cnt_next < CNT_W'(MAX_OUTST));

  hart_miss_ctrl_rr_arbiter #(.N(HART_NUM)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (pend_next),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    grant_id   = '0;
    grant_addr = '0;
    grant_dc   = 1'b0;
    for (int i = 0; i < HART_NUM; i++) begin
      if (grant[i]) begin
        grant_id   = HART_ID_W'(i);
        grant_addr = addr_nx[i];
        grant_dc   = is_dc_nx[i];
      end
    end
  end

  always_comb begin
    req_valid_next   = req_valid_reg;
    req_hart_id_next = req_hart_id_reg;
    req_addr_next    = req_addr_reg;
    req_is_dc_next   = req_is_dc_reg;
    if (arb_en) begin
      req_valid_next   = |grant;
      req_hart_id_next = grant_id;
      req_addr_next    = grant_addr;
      req_is_dc_next   = grant_dc;
    end else if (hs) begin
      req_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_valid_reg   <= 1'b0;
      req_hart_id_reg <= '0;
      req_addr_reg    <= '0;
      req_is_dc_reg   <= 1'b0;
      cnt_reg         <= '0;
      err_reg         <= 1'b0;
    end else begin
      req_valid_reg   <= req_valid_next;
      req_hart_id_reg <= req_hart_id_next;
      req_addr_reg    <= req_addr_next;
      req_is_dc_reg   <= req_is_dc_next;
      cnt_reg         <= cnt_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    resume_hart_id = '0;
    resume_pc      = '0;
    for (int i = 0; i < HART_NUM; i++) begin
      if (resume_vec[i]) begin
        resume_hart_id = HART_ID_W'(i);
        resume_pc      = pc_cur[i];
      end
    end
  end

  assign resume_valid = |resume_vec;
  assign req_valid    = req_valid_reg;
  assign req_hart_id  = req_hart_id_reg;
  assign req_addr     = req_addr_reg;
  assign req_is_dc    = req_is_dc_reg;
  assign outst_cnt    = cnt_reg;
  assign err          = err_reg;

endmodule
